count_seq_checker: RTL and testbench



---
 rtl/count_seq_pkg.sv | 13 +
 rtl/count_seq_checker_sat_counter.sv | 16 +
 rtl/count_seq_checker.sv | 95 +++++++++
 tb/tb_count_seq_checker.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/count_seq_pkg.sv
// count_seq_pkg: shared state encoding, default parameters and saturating increment for count_seq_checker
package count_seq_pkg;
  typedef enum logic [1:0] {IDLE, SYNC, LOCKED, FAULT} state_t;
  localparam int DEF_WIDTH  = 4;
  localparam int DEF_LOCK_N = 3;
  localparam int DEF_ERR_W  = 8;
  localparam int DEF_WRAP_W = 8;
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int w);
    logic [63:0] m;
    m = (w >= 64) ? '1 : (64'd1 << w) - 64'd1;
    return (v >= m) ? v : v + 64'd1;
  endfunction
endpackage

// File: rtl/count_seq_checker_sat_counter.sv
// sat_counter: W-bit up-counter that sticks at all-ones, with synchronous clear
module sat_counter
  import count_seq_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_q;
  always_ff @(posedge clk) r_q <= (rst || i_clr) ? '0 : i_inc ? W'(sat_inc(64'(r_q), W)) : r_q;
  assign o_q = r_q;
endmodule

// File: rtl/count_seq_checker.sv
// count_seq_checker: locks onto an increment-by-one count stream and flags skips/holds/resets.
// Optional coverage outputs seen_mask/all_seen when COUNT_SEQ_CHECKER_COV_EN is defined.
module count_seq_checker
  import count_seq_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int LOCK_N = DEF_LOCK_N,
  parameter int ERR_W  = DEF_ERR_W,
  parameter int WRAP_W = DEF_WRAP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [WIDTH-1:0]  count,
  input  logic              clear,
  output logic              locked,
  output logic              err_pulse,
  output logic              err_flag,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic [WIDTH-1:0]  exp_count
`ifdef COUNT_SEQ_CHECKER_COV_EN
  ,
  output logic [2**WIDTH-1:0] seen_mask,
  output logic                all_seen
`endif
);
  state_t           r_state;
  logic [3:0]       r_streak;
  logic [WIDTH-1:0] r_exp;
  logic             r_pulse;
  logic             r_flag;
  logic             w_clr;
  logic             w_match;
  logic             w_err;
  logic             w_wrap;
  logic [3:0]       w_streak_inc;
  logic             w_lock;
  assign w_clr        = rst | clear;
  assign w_match      = count == r_exp;
  // errors only count once the stream has been locked at least once (LOCKED or FAULT)
  assign w_err        = en && !w_match && (r_state == LOCKED || r_state == FAULT);
  assign w_wrap       = en && w_match && r_state == LOCKED && count == '1;
  assign w_streak_inc = r_streak + 4'd1;
  assign w_lock       = w_streak_inc == 4'(LOCK_N);
  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_state  <= IDLE;
      r_streak <= '0;
      r_exp    <= '0;
      r_pulse  <= 1'b0;
      r_flag   <= 1'b0;
    end else begin
      r_pulse <= w_err;
      if (w_err) r_flag <= 1'b1;
      if (en) begin
        r_exp <= count + WIDTH'(1);
        case (r_state)
          IDLE: begin
            r_state  <= SYNC;
            r_streak <= '0;
          end
          LOCKED: if (!w_match) begin
            r_state  <= FAULT;
            r_streak <= '0;
          end
          default: if (!w_match) r_streak <= '0;
          else if (w_lock) begin
            r_state  <= LOCKED;
            r_streak <= '0;
          end else r_streak <= w_streak_inc;
        endcase
      end
    end
  end
  sat_counter #(.W(ERR_W)) u_err (
    .clk(clk), .rst(rst), .i_clr(clear), .i_inc(w_err), .o_q(err_cnt)
  );
  sat_counter #(.W(WRAP_W)) u_wrap (
    .clk(clk), .rst(rst), .i_clr(clear), .i_inc(w_wrap), .o_q(wrap_cnt)
  );
  assign locked    = r_state == LOCKED;
  assign err_pulse = r_pulse;
  assign err_flag  = r_flag;
  assign exp_count = r_exp;
`ifdef COUNT_SEQ_CHECKER_COV_EN
  logic [2**WIDTH-1:0] r_seen;
  always_ff @(posedge clk) begin
    if (w_clr) r_seen <= '0;
    else if (en && r_state == LOCKED) r_seen[count] <= 1'b1;
  end
  assign seen_mask = r_seen;
  assign all_seen  = &r_seen;
`endif
endmodule

// File: tb/tb_count_seq_checker.sv
// tb_count_seq_checker: table vectors, corner sequences and random stimulus against a run-length reference model
module tb_count_seq_checker;
  localparam int LOCK_N = 3;
  logic       clk = 0;
  logic       rst = 1;
  logic       en = 0;
  logic       clear = 0;
  logic [3:0] count = 0;
  logic       locked, err_pulse, err_flag;
  logic [7:0] err_cnt, wrap_cnt;
  logic [3:0] exp_count;
  logic       locked2, err_pulse2, err_flag2;
  logic [1:0] err_cnt2;
  logic [7:0] wrap_cnt2;
  logic [3:0] exp_count2;
`ifdef COUNT_SEQ_CHECKER_COV_EN
  logic [15:0] seen_mask, seen_mask2;
  logic        all_seen, all_seen2;
`endif
  always #5 clk = ~clk;

  count_seq_checker #(.WIDTH(4), .LOCK_N(LOCK_N), .ERR_W(8), .WRAP_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .count(count), .clear(clear),
    .locked(locked), .err_pulse(err_pulse), .err_flag(err_flag),
    .err_cnt(err_cnt), .wrap_cnt(wrap_cnt), .exp_count(exp_count)
`ifdef COUNT_SEQ_CHECKER_COV_EN
    , .seen_mask(seen_mask), .all_seen(all_seen)
`endif
  );
  count_seq_checker #(.WIDTH(4), .LOCK_N(LOCK_N), .ERR_W(2), .WRAP_W(8)) dut2 (
    .clk(clk), .rst(rst), .en(en), .count(count), .clear(clear),
    .locked(locked2), .err_pulse(err_pulse2), .err_flag(err_flag2),
    .err_cnt(err_cnt2), .wrap_cnt(wrap_cnt2), .exp_count(exp_count2)
`ifdef COUNT_SEQ_CHECKER_COV_EN
    , .seen_mask(seen_mask2), .all_seen(all_seen2)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;
  // model: lock status is derived from the length of the trailing run of +1 steps
  int          m_samples, m_run, m_err, m_err2, m_wrap;
  bit          m_ever, m_pulse, m_flag;
  logic [3:0]  m_last;
  logic [15:0] m_seen;

  task automatic chk(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model(input logic e, input logic c, input logic [3:0] v, input logic r);
    bit was_locked, match;
    m_pulse = 0;
    if (r || c) begin
      m_samples = 0; m_run = 0; m_err = 0; m_err2 = 0; m_wrap = 0;
      m_ever = 0; m_flag = 0; m_last = 0; m_seen = 0;
      return;
    end
    if (!e) return;
    was_locked = m_samples > 0 && m_run >= LOCK_N;
    if (was_locked) m_seen[v] = 1'b1;
    if (m_samples > 0) begin
      match = v == 4'(m_last + 4'd1);
      if (match) begin
        if (was_locked && v == 4'd15 && m_wrap < 255) m_wrap++;
        m_run++;
      end else begin
        if (m_ever) begin
          m_pulse = 1; m_flag = 1;
          if (m_err < 255) m_err++;
          if (m_err2 < 3) m_err2++;
        end
        m_run = 0;
      end
      if (m_run >= LOCK_N) m_ever = 1;
    end
    m_samples++;
    m_last = v;
  endtask

  task automatic check_model();
    chk("locked", locked, m_samples > 0 && m_run >= LOCK_N);
    chk("err_pulse", err_pulse, m_pulse);
    chk("err_flag", err_flag, m_flag);
    chk("err_cnt", err_cnt, m_err);
    chk("err_cnt_sat2", err_cnt2, m_err2);
    chk("wrap_cnt", wrap_cnt, m_wrap);
    chk("exp_count", exp_count, m_samples > 0 ? 4'(m_last + 4'd1) : 4'd0);
`ifdef COUNT_SEQ_CHECKER_COV_EN
    chk("seen_mask", seen_mask, m_seen);
    chk("all_seen", all_seen, &m_seen);
`endif
  endtask

  task automatic step(input logic e, input logic c, input logic [3:0] v, input logic r);
    @(negedge clk);
    en = e; clear = c; count = v; rst = r;
    @(posedge clk);
    #1;
    model(e, c, v, r);
    check_model();
  endtask

  typedef struct {
    logic e, c; logic [3:0] v;
    logic lk, pl, fl; int ec, wc; logic [3:0] ex;
  } vec_t;
  vec_t tv[$];

  task automatic add(input logic e, c, input int v, lk, pl, fl, ec, wc, ex);
    tv.push_back('{e, c, 4'(v), 1'(lk), 1'(pl), 1'(fl), ec, wc, 4'(ex)});
  endtask

  initial begin
    logic [3:0] rc;
    int r;
    // lock on 5..8, run through a wrap, skip 3->5, relock, then clear and hold/en gating
    add(1,0,5, 0,0,0,0,0,6); add(1,0,6, 0,0,0,0,0,7);
    add(1,0,7, 0,0,0,0,0,8); add(1,0,8, 1,0,0,0,0,9);
    for (int i = 9; i <= 14; i++) add(1,0,i, 1,0,0,0,0,i+1);
    add(1,0,15, 1,0,0,0,1,0); add(1,0,0, 1,0,0,0,1,1);
    for (int i = 1; i <= 3; i++) add(1,0,i, 1,0,0,0,1,i+1);
    add(1,0,5, 0,1,1,1,1,6); add(1,0,6, 0,0,1,1,1,7);
    add(1,0,7, 0,0,1,1,1,8); add(1,0,8, 1,0,1,1,1,9);
    add(0,1,0, 0,0,0,0,0,0);
    for (int i = 1; i <= 3; i++) add(1,0,i, 0,0,0,0,0,i+1);
    add(1,0,4, 1,0,0,0,0,5);
    for (int i = 0; i < 3; i++) add(0,0,9, 1,0,0,0,0,5);
    add(1,0,5, 1,0,0,0,0,6); add(1,0,5, 0,1,1,1,0,6);

    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("rst_locked", locked, 0);
    chk("rst_exp", exp_count, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_wrap_cnt", wrap_cnt, 0);
    foreach (tv[i]) begin
      step(tv[i].e, tv[i].c, tv[i].v, 0);
      chk($sformatf("tv%0d_locked", i), locked, tv[i].lk);
      chk($sformatf("tv%0d_pulse", i), err_pulse, tv[i].pl);
      chk($sformatf("tv%0d_flag", i), err_flag, tv[i].fl);
      chk($sformatf("tv%0d_errcnt", i), err_cnt, tv[i].ec);
      chk($sformatf("tv%0d_wrap", i), wrap_cnt, tv[i].wc);
      chk($sformatf("tv%0d_exp", i), exp_count, tv[i].ex);
    end
    // five more holds in FAULT: 2-bit counter must stick at 3
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 5, 0);
      chk("fault_pulse", err_pulse, 1);
    end
    chk("sat_err_cnt2", err_cnt2, 3);
    chk("wide_err_cnt", err_cnt, 6);
    step(0, 0, 5, 0);
    chk("sat_hold", err_cnt2, 3);
    chk("pulse_drop_en0", err_pulse, 0);
    // clear with en=1 wins; the sample is ignored
    step(1, 1, 6, 0);
    chk("clr_err_cnt", err_cnt, 0);
    chk("clr_flag", err_flag, 0);
    chk("clr_exp", exp_count, 0);
    chk("clr_locked", locked, 0);
    step(1, 0, 7, 0);
    chk("post_clr_first_exp", exp_count, 8);
    chk("post_clr_no_err", err_cnt, 0);
`ifdef COUNT_SEQ_CHECKER_COV_EN
    for (int i = 13; i <= 15; i++) step(1, 0, 4'(i - 5), 0);
    chk("cov_locked", locked, 1);
    for (int k = 0; k < 32; k++) step(1, 0, 4'(k + 11), 0);
    chk("cov_mask", seen_mask, 16'hFFFF);
    chk("cov_all", all_seen, 1);
    step(0, 0, 0, 1);
    chk("cov_rst_mask", seen_mask, 0);
`endif
    rc = 0;
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 3) step(1, 1, 4'($urandom), 0);
      else if (r < 12) step(0, 0, 4'($urandom), 0);
      else begin
        r = int'($urandom_range(0, 99));
        rc = r < 84 ? rc + 4'd1 : r < 92 ? rc : 4'($urandom);
        step(1, 0, rc, 0);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
